ram_req_ctrl: RTL and testbench
===============================

Name: ram_req_ctrl

Overview:
- Request controller that sits directly upstream of the banked single-port synchronous RAM and is its only bus master.
- Accepts read/write requests over a valid/ready handshake and sequences the RAM strobes (addr, cs, we, oe).
- Owns the bidirectional data bus: drives it on writes, releases it on reads.
- Returns read data over a valid/ready response channel.

Parameters:
- ADDR_WIDTH, 8, address width; equals the RAM's ADDR_WIDTH; top 2 bits select the bank inside the RAM.
- DATA_WIDTH, 8, data bus width; equals the RAM's DATA_WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  controller can accept a request this cycle.
- req_we  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_WIDTH  request address.
- req_wdata  input  DATA_WIDTH  write data.
- rsp_valid  output  1  read data valid.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DATA_WIDTH  read data.
- mem_addr  output  ADDR_WIDTH  RAM address.
- mem_data  inout  DATA_WIDTH  RAM data bus.
- mem_cs  output  1  RAM chip select.
- mem_we  output  1  RAM write enable.
- mem_oe  output  1  RAM output enable.
- busy  output  1  1 whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; req_ready = 1; rsp_valid = 0; rsp_rdata = 0.
  - mem_addr = 0; mem_cs = mem_we = mem_oe = 0; mem_data released (high-Z); busy = 0.
- Register outputs:
  - mem_* strobes and mem_addr are registered; no combinational path from req_* to mem_*.
  - req_ready is high only in IDLE.
- Request acceptance: req_valid & req_ready at a rising edge.
  - Captures req_addr into mem_addr and req_wdata into an internal write register.
  - Unaccepted requests are ignored.
- States:
  - IDLE: on accept with req_we = 1, go to WR; on accept with req_we = 0, go to RD0.
  - WR (1 cycle):
    - Drives mem_cs = 1, mem_we = 1, mem_oe = 0, and drives mem_data from the write register.
    - RAM writes at the closing edge; next state is IDLE.
    - Write latency: accept edge to RAM write edge = 1 cycle. A write produces no response.
  - RD0 (1 cycle):
    - Drives mem_cs = 1, mem_we = 0, mem_oe = 1; mem_data released.
    - RAM registers its output at the closing edge; next state is RD1.
  - RD1 (1 cycle):
    - Keeps mem_cs = 1 and mem_oe = 1.
    - Samples mem_data into rsp_rdata at the closing edge; sets rsp_valid = 1; next state is RSP.
  - RSP:
    - mem_cs = mem_oe = 0; holds rsp_valid and rsp_rdata stable.
    - On rsp_ready, clears rsp_valid and goes to IDLE.
- Read latency: accept edge to rsp_valid high = 2 cycles; minimum read throughput is 1 per 4 cycles.
- Bus ownership:
  - mem_data is driven only in WR; high-Z in every other state and in reset.
  - The controller never drives mem_data while mem_oe = 1.
- Boundaries:
  - Back-to-back requests: a new request is accepted on the first IDLE cycle after the previous operation.
  - rsp_ready held high stalls nothing extra; RSP lasts exactly 1 cycle.
  - rsp_ready low holds RSP indefinitely; req_ready stays 0 for that whole time.
  - Address wrap: all-ones address is legal; no address arithmetic is performed.
  - Reset mid-operation: an in-flight write may or may not complete in the RAM; an in-flight read is discarded (rsp_valid = 0); the bus is released immediately on rst_n low.
  - Unused states decode to IDLE.

Optional Feature:
- Macro: RAM_REQ_CTRL_TURNAROUND_EN.
- Defined:
  - Adds a TA state (1 idle cycle with all strobes 0 and the bus at high-Z) between RSP and the next operation when that operation is a write.
  - Write-after-read latency grows by 1 cycle; all other sequences are unchanged.
- Undefined:
  - No TA state; a write may follow a read on the first IDLE cycle.

Test Plan:
- Reset check: assert rst_n = 0 mid-RD0 -> mem_cs = mem_oe = 0, mem_data high-Z, rsp_valid = 0, req_ready = 1 asynchronously.
- Write then read: write 0xA5 to 0x03, then read 0x03 -> rsp_rdata = 0xA5 exactly 2 cycles after the read-accept edge.
- Bank coverage: write 0x11/0x22/0x33/0x44 to 0x05/0x45/0x85/0xC5, then read all four back -> same values in order, no cross-bank aliasing.
- Backpressure: read 0xFF with rsp_ready = 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready = 0, no mem_cs pulses; response clears on the first rsp_ready = 1.
- Bus contention check: alternating read/write stream of 8 requests -> mem_data is never driven while mem_oe = 1.
  - With RAM_REQ_CTRL_TURNAROUND_EN defined, each write-after-read shows one extra all-strobes-low cycle.
- Ignored request: req_valid pulsed while busy = 1 -> not accepted, no change to mem_addr.

Source files
------------

// File: rtl/ram_req_ctrl.sv
// Request sequencer and sole bus master for the banked single-port synchronous RAM.
// Optional build macro RAM_REQ_CTRL_TURNAROUND_EN inserts one bus-turnaround cycle before a write that follows a read.
module ram_req_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic                  busy
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_RD0  = 3'd2,
    S_RD1  = 3'd3,
    S_RSP  = 3'd4,
    S_TA   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  cs_q, cs_d;
  logic                  we_q, we_d;
  logic                  oe_q, oe_d;
  logic                  drv_q, drv_d;
`ifdef RAM_REQ_CTRL_TURNAROUND_EN
  logic                  last_rd_q, last_rd_d;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    rsp_valid_d = rsp_valid_q;
`ifdef RAM_REQ_CTRL_TURNAROUND_EN
    last_rd_d   = last_rd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (req_we) begin
`ifdef RAM_REQ_CTRL_TURNAROUND_EN
            state_d = last_rd_q ? S_TA : S_WR;
`else
            state_d = S_WR;
`endif
          end else begin
            state_d = S_RD0;
          end
        end
      end
`ifdef RAM_REQ_CTRL_TURNAROUND_EN
      S_TA: begin
        last_rd_d = 1'b0;
        state_d   = S_WR;
      end
`endif
      S_WR:  state_d = S_IDLE;
      S_RD0: state_d = S_RD1;
      S_RD1: begin
        // RAM output register was loaded at the close of RD0 and is on the bus now
        rdata_d     = mem_data;
        rsp_valid_d = 1'b1;
        state_d     = S_RSP;
`ifdef RAM_REQ_CTRL_TURNAROUND_EN
        last_rd_d   = 1'b1;
`endif
      end
      S_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they change on the same edge as the state
    cs_d  = (state_d == S_WR) || (state_d == S_RD0) || (state_d == S_RD1);
    we_d  = (state_d == S_WR);
    oe_d  = (state_d == S_RD0) || (state_d == S_RD1);
    drv_d = (state_d == S_WR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      oe_q        <= 1'b0;
      drv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rdata_q     <= rdata_d;
      rsp_valid_q <= rsp_valid_d;
      cs_q        <= cs_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      drv_q       <= drv_d;
    end
  end

  always_ff @(posedge clk) begin
    wdata_q <= wdata_d;
  end

`ifdef RAM_REQ_CTRL_TURNAROUND_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_rd_q <= 1'b0;
    end else begin
      last_rd_q <= last_rd_d;
    end
  end
`endif

  assign mem_data  = drv_q ? wdata_q : {DATA_WIDTH{1'bz}};
  assign mem_addr  = addr_q;
  assign mem_cs    = cs_q;
  assign mem_we    = we_q;
  assign mem_oe    = oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: behavioural RAM on the shared bus plus a transaction-level memory model.
module tb_ram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_we;
  logic [7:0] req_addr, req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata, mem_addr;
  wire  [7:0] mem_data;
  logic       mem_cs, mem_we, mem_oe, busy;

  ram_req_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM: write on cs&we, registered read on cs&~we, drives bus under oe
  logic [7:0] ram [256];
  logic [7:0] ram_q;
  always @(posedge clk) begin
    if (mem_cs && mem_we) ram[mem_addr] <= mem_data;
    if (mem_cs && !mem_we) ram_q <= ram[mem_addr];
  end
  assign mem_data = (mem_cs && mem_oe) ? ram_q : 8'bz;

  logic [7:0] exp_mem [256];
  logic       last_rd;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [7:0] data);
    chk("wr_idle_ready", 32'(req_ready), 1);
    chk("wr_idle_busy", 32'(busy), 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = addr; req_wdata = data;
    @(negedge clk);
    req_valid = 1'b0; req_addr = ~addr; req_wdata = ~data;
`ifdef RAM_REQ_CTRL_TURNAROUND_EN
    if (last_rd) begin
      chk("ta_strobes", 32'({mem_cs, mem_we, mem_oe}), 0);
      chk("ta_busy", 32'(busy), 1);
      chk("ta_ready", 32'(req_ready), 0);
      @(negedge clk);
    end
`endif
    chk("wr_strobes", 32'({mem_cs, mem_we, mem_oe}), 32'b110);
    chk("wr_addr", 32'(mem_addr), 32'(addr));
    chk("wr_bus", 32'(mem_data), 32'(data));
    chk("wr_ready", 32'(req_ready), 0);
    chk("wr_rsp_valid", 32'(rsp_valid), 0);
    exp_mem[addr] = data;
    last_rd = 1'b0;
    @(negedge clk);
    chk("wr_done_cs", 32'(mem_cs), 0);
  endtask

  task automatic do_read(input logic [7:0] addr, input int stall, input bit poke);
    logic [7:0] exp;
    exp = exp_mem[addr];
    chk("rd_idle_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = addr; req_wdata = $urandom;
    @(negedge clk);
    req_valid = 1'b0;
    rsp_ready = (stall == 0);
    chk("rd0_strobes", 32'({mem_cs, mem_we, mem_oe}), 32'b101);
    chk("rd0_addr", 32'(mem_addr), 32'(addr));
    chk("rd0_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("rd1_strobes", 32'({mem_cs, mem_we, mem_oe}), 32'b101);
    chk("rd1_rsp_valid", 32'(rsp_valid), 0);
    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 1);
    chk("rsp_rdata", 32'(rsp_rdata), 32'(exp));
    chk("rsp_strobes", 32'({mem_cs, mem_oe}), 0);
    chk("rsp_ready_out", 32'(req_ready), 0);
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        req_valid = 1'b1; req_we = 1'($urandom); req_addr = ~addr; req_wdata = $urandom;
      end
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 1);
      chk("stall_rdata", 32'(rsp_rdata), 32'(exp));
      chk("stall_req_ready", 32'(req_ready), 0);
      chk("stall_cs", 32'(mem_cs), 0);
      chk("stall_addr", 32'(mem_addr), 32'(addr));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rsp_cleared", 32'(rsp_valid), 0);
    chk("rsp_idle_ready", 32'(req_ready), 1);
    chk("rsp_idle_busy", 32'(busy), 0);
    last_rd = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, d;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'h00;
      exp_mem[i] = 8'h00;
    end
    ram_q = 8'h00;
    last_rd = 1'b0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    rsp_ready = 1'b1;
    #3;
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({mem_cs, mem_we, mem_oe}), 0);
    chk("rst_rsp", 32'({rsp_valid, rsp_rdata}), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_write(8'h03, 8'hA5);
    do_read(8'h03, 0, 1'b0);

    do_write(8'h05, 8'h11);
    do_write(8'h45, 8'h22);
    do_write(8'h85, 8'h33);
    do_write(8'hC5, 8'h44);
    do_read(8'h05, 0, 1'b0);
    do_read(8'h45, 0, 1'b0);
    do_read(8'h85, 0, 1'b0);
    do_read(8'hC5, 0, 1'b0);

    do_write(8'hFF, 8'h5A);
    do_read(8'hFF, 5, 1'b1);

    for (int i = 0; i < 8; i++) begin
      a = 8'(i * 37 + 9);
      if (i % 2 == 0) do_write(a, 8'(8'hF0 ^ i));
      else            do_read(8'(a - 8'd37), 0, 1'b0);
    end

    // Reset in the middle of a read: everything returns to the idle state without a clock edge
    do_write(8'h10, 8'h77);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrd_cs", 32'(mem_cs), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_strobes", 32'({mem_cs, mem_we, mem_oe}), 0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 0);
    chk("midrst_rdata", 32'(rsp_rdata), 0);
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_addr", 32'(mem_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = 1'b0;
    @(negedge clk);
    do_read(8'h10, 0, 1'b0);

    for (int n = 0; n < 150; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
      d = 8'($urandom);
      if ($urandom_range(0, 1) == 1) do_write(a, d);
      else do_read(a, $urandom_range(0, 3), 1'($urandom));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        @(negedge clk);
        chk("gap_idle", 32'({busy, mem_cs}), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
